ccu_snoop_arbiter: RTL and testbench

CCU_SNOOP_ARBITER -- requirements
Module: ccu_snoop_arbiter

---
 rtl/ccu_snoop_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ccu_snoop_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_snoop_arbiter.sv
// Snoop arbiter between the read- and write-snoop FSMs of the CCU: round-robin AC arbitration
// with owner queues that steer CR and CD responses back to the requester that issued the snoop.
package ace_pkg;
   typedef struct packed {
      logic WasUnique;
      logic IsShared;
      logic PassDirty;
      logic Error;
      logic DataTransfer;
   } crresp_t;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } cd_chan_t;
endpackage

// Single-bit owner FIFO; Depth must be a power of two so the pointers wrap naturally.
module ccu_owner_fifo #(
   parameter int unsigned Depth = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  logic data_i,
   input  logic pop_i,
   output logic data_o,
   output logic full_o,
   output logic empty_o
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Depth-1:0] mem_q;
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  cnt_q;

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (push_i && !pop_i) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (!push_i && pop_i) begin
            cnt_q <= cnt_q - CntW'(1);
         end
      end
   end
endmodule

module ccu_snoop_arbiter #(
   parameter type         ac_chan_t      = logic,
   parameter type         cr_chan_t      = ace_pkg::crresp_t,
   parameter type         cd_chan_t      = ace_pkg::cd_chan_t,
   parameter type         domain_mask_t  = logic,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic         [1:0] req_ac_valid_i,
   input  ac_chan_t     [1:0] req_ac_i,
   input  domain_mask_t [1:0] req_mask_i,
   output logic         [1:0] req_ac_ready_o,
   output logic         [1:0] req_cr_valid_o,
   output cr_chan_t           req_cr_o,
   input  logic         [1:0] req_cr_ready_i,
   output logic         [1:0] req_cd_valid_o,
   output cd_chan_t           req_cd_o,
   input  logic         [1:0] req_cd_ready_i,
   output logic               ac_valid_o,
   output ac_chan_t           ac_o,
   output domain_mask_t       domain_mask_o,
   input  logic               ac_ready_i,
   input  logic               cr_valid_i,
   input  cr_chan_t           cr_i,
   output logic               cr_ready_o,
   input  logic               cd_valid_i,
   input  cd_chan_t           cd_i,
   output logic               cd_ready_o
);
   logic grant;
   logic last_q;
   logic lock_q;
   logic locked_idx_q;
   logic ac_hs;
   logic cr_owner, cr_full, cr_empty, cr_hs, cr_stall;
   logic cd_owner, cd_full, cd_empty, cd_push, cd_pop;

   // Lock holds a stalled grant stable; otherwise prefer the requester not served last.
   always_comb begin
      grant = 1'b0;
      if (lock_q) begin
         grant = locked_idx_q;
      end else if (&req_ac_valid_i) begin
         grant = ~last_q;
      end else begin
         grant = req_ac_valid_i[1];
      end
   end

   always_comb begin
      req_ac_ready_o        = '0;
      ac_valid_o            = rst_ni && req_ac_valid_i[grant] && !cr_full;
      req_ac_ready_o[grant] = rst_ni && ac_ready_i && !cr_full;
   end

   assign ac_o          = req_ac_i[grant];
   assign domain_mask_o = req_mask_i[grant];
   assign ac_hs         = ac_valid_o && ac_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q       <= 1'b1;
         lock_q       <= 1'b0;
         locked_idx_q <= 1'b0;
      end else if (ac_hs) begin
         last_q <= grant;
         lock_q <= 1'b0;
      end else if (ac_valid_o) begin
         lock_q       <= 1'b1;
         locked_idx_q <= grant;
      end
   end

   ccu_owner_fifo #(.Depth(MaxOutstanding)) i_cr_owner_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (ac_hs),
      .data_i  (grant),
      .pop_i   (cr_hs),
      .data_o  (cr_owner),
      .full_o  (cr_full),
      .empty_o (cr_empty)
   );

   // A data-carrying CR must not complete while there is no room to record its CD owner.
   assign cr_stall = cd_full && cr_i.DataTransfer;

   always_comb begin
      req_cr_valid_o           = '0;
      req_cr_valid_o[cr_owner] = cr_valid_i && !cr_empty && !cr_stall;
      cr_ready_o               = req_cr_ready_i[cr_owner] && !cr_empty && !cr_stall;
   end

   assign req_cr_o = cr_i;
   assign cr_hs    = cr_valid_i && cr_ready_o;
   assign cd_push  = cr_hs && cr_i.DataTransfer;

   ccu_owner_fifo #(.Depth(MaxOutstanding)) i_cd_owner_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (cd_push),
      .data_i  (cr_owner),
      .pop_i   (cd_pop),
      .data_o  (cd_owner),
      .full_o  (cd_full),
      .empty_o (cd_empty)
   );

   always_comb begin
      req_cd_valid_o           = '0;
      req_cd_valid_o[cd_owner] = cd_valid_i && !cd_empty;
      cd_ready_o               = req_cd_ready_i[cd_owner] && !cd_empty;
   end

   assign req_cd_o = cd_i;
   assign cd_pop   = cd_valid_i && cd_ready_o && cd_i.last;
endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Directed bench for ccu_snoop_arbiter: arbitration, locking, owner-queue routing, back-pressure, reset.
module tb_ccu_snoop_arbiter;
   typedef struct packed {
      logic [15:0] addr;
      logic [3:0]  snoop;
      logic [2:0]  prot;
   } ac_t;
   typedef logic [3:0] mask_t;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic        [1:0] req_ac_valid;
   ac_t         [1:0] req_ac;
   mask_t       [1:0] req_mask;
   logic        [1:0] req_ac_ready_o;
   logic        [1:0] req_cr_valid_o;
   ace_pkg::crresp_t  req_cr_o;
   logic        [1:0] req_cr_ready;
   logic        [1:0] req_cd_valid_o;
   ace_pkg::cd_chan_t req_cd_o;
   logic        [1:0] req_cd_ready;
   logic              ac_valid_o;
   ac_t               ac_o;
   mask_t             domain_mask_o;
   logic              ac_ready;
   logic              cr_valid;
   ace_pkg::crresp_t  cr;
   logic              cr_ready_o;
   logic              cd_valid;
   ace_pkg::cd_chan_t cd;
   logic              cd_ready_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   ccu_snoop_arbiter #(
      .ac_chan_t      (ac_t),
      .cr_chan_t      (ace_pkg::crresp_t),
      .cd_chan_t      (ace_pkg::cd_chan_t),
      .domain_mask_t  (mask_t),
      .MaxOutstanding (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_ac_valid_i (req_ac_valid),
      .req_ac_i       (req_ac),
      .req_mask_i     (req_mask),
      .req_ac_ready_o (req_ac_ready_o),
      .req_cr_valid_o (req_cr_valid_o),
      .req_cr_o       (req_cr_o),
      .req_cr_ready_i (req_cr_ready),
      .req_cd_valid_o (req_cd_valid_o),
      .req_cd_o       (req_cd_o),
      .req_cd_ready_i (req_cd_ready),
      .ac_valid_o     (ac_valid_o),
      .ac_o           (ac_o),
      .domain_mask_o  (domain_mask_o),
      .ac_ready_i     (ac_ready),
      .cr_valid_i     (cr_valid),
      .cr_i           (cr),
      .cr_ready_o     (cr_ready_o),
      .cd_valid_i     (cd_valid),
      .cd_i           (cd),
      .cd_ready_o     (cd_ready_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance from one falling edge to the next; inputs change and checks run between edges.
   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic chk_all_quiet(input string tag);
      chk({tag, "_ac_valid"}, 32'(ac_valid_o), 32'h0);
      chk({tag, "_ac_ready"}, 32'(req_ac_ready_o), 32'h0);
      chk({tag, "_cr_ready"}, 32'(cr_ready_o), 32'h0);
      chk({tag, "_cd_ready"}, 32'(cd_ready_o), 32'h0);
      chk({tag, "_req_cr_valid"}, 32'(req_cr_valid_o), 32'h0);
      chk({tag, "_req_cd_valid"}, 32'(req_cd_valid_o), 32'h0);
   endtask

   initial begin
      logic [1:0] exp_route [4];
      rst_ni       = 1'b0;
      req_ac_valid = 2'b00;
      req_ac[0]    = '{addr: 16'h0100, snoop: 4'h1, prot: 3'h0};
      req_ac[1]    = '{addr: 16'h0200, snoop: 4'h2, prot: 3'h1};
      req_mask[0]  = 4'h1;
      req_mask[1]  = 4'h2;
      req_cr_ready = 2'b00;
      req_cd_ready = 2'b00;
      ac_ready     = 1'b0;
      cr_valid     = 1'b0;
      cr           = '0;
      cd_valid     = 1'b0;
      cd           = '0;

      // Reset with every input pushing
      @(negedge clk_i);
      req_ac_valid = 2'b11; ac_ready = 1'b1; cr_valid = 1'b1; cd_valid = 1'b1;
      req_cr_ready = 2'b11; req_cd_ready = 2'b11;
      #1;
      chk_all_quiet("rst");
      req_ac_valid = 2'b00; ac_ready = 1'b0; cr_valid = 1'b0; cd_valid = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();

      // Round-robin with both requesters valid
      req_ac_valid = 2'b11; ac_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_ready", 32'(req_ac_ready_o), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_addr", 32'(ac_o.addr), (i % 2 == 0) ? 32'h100 : 32'h200);
         chk("rr_mask", 32'(domain_mask_o), (i % 2 == 0) ? 32'h1 : 32'h2);
         tick();
      end
      // CR queue full: AC blocked, CR drains head owner 0
      cr_valid = 1'b1; cr = '0;
      #1;
      chk("full_ac_valid", 32'(ac_valid_o), 32'h0);
      chk("full_ac_ready", 32'(req_ac_ready_o), 32'h0);
      chk("full_cr_route", 32'(req_cr_valid_o), 32'h1);
      chk("full_cr_ready", 32'(cr_ready_o), 32'h1);
      tick();
      // One slot free: AC accepted while CR pops owner 1
      #1;
      chk("refill_ac_valid", 32'(ac_valid_o), 32'h1);
      chk("refill_ac_ready", 32'(req_ac_ready_o), 32'h1);
      chk("refill_cr_route", 32'(req_cr_valid_o), 32'h2);
      tick();
      req_ac_valid = 2'b00;
      exp_route = '{2'b01, 2'b10, 2'b01, 2'b00};
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("drain_cr_route", 32'(req_cr_valid_o), 32'(exp_route[i]));
         tick();
      end
      #1;
      chk("empty_cr_ready", 32'(cr_ready_o), 32'h0);
      chk("empty_cr_route", 32'(req_cr_valid_o), 32'h0);
      cr_valid = 1'b0;

      // Lock: requester 1 stalled, requester 0 joins, grant must not move
      req_ac_valid = 2'b10; ac_ready = 1'b1;
      #1;
      chk("pre_lock_ready", 32'(req_ac_ready_o), 32'h2);
      tick();
      ac_ready = 1'b0;
      #1;
      chk("lock_ac_valid", 32'(ac_valid_o), 32'h1);
      chk("lock_addr", 32'(ac_o.addr), 32'h200);
      chk("lock_ready", 32'(req_ac_ready_o), 32'h0);
      tick();
      req_ac_valid = 2'b11;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("lock_hold_addr", 32'(ac_o.addr), 32'h200);
         chk("lock_hold_mask", 32'(domain_mask_o), 32'h2);
         tick();
      end
      ac_ready = 1'b1;
      #1;
      chk("lock_hs_addr", 32'(ac_o.addr), 32'h200);
      chk("lock_hs_ready", 32'(req_ac_ready_o), 32'h2);
      tick();
      #1;
      chk("post_lock_addr", 32'(ac_o.addr), 32'h100);
      chk("post_lock_ready", 32'(req_ac_ready_o), 32'h1);
      tick();
      req_ac_valid = 2'b00;

      // CR routing into CD queue (owners queued: 1,1,0)
      cr_valid = 1'b1; cr = '0;
      #1;
      chk("cr_plain_route", 32'(req_cr_valid_o), 32'h2);
      tick();
      cr.DataTransfer = 1'b1; cd_valid = 1'b1; cd = '{data: 32'hD0, last: 1'b0};
      #1;
      chk("cr_dt_route", 32'(req_cr_valid_o), 32'h2);
      chk("cr_dt_ready", 32'(cr_ready_o), 32'h1);
      chk("cd_no_bypass", 32'(cd_ready_o), 32'h0);
      chk("cd_no_bypass_valid", 32'(req_cd_valid_o), 32'h0);
      tick();
      cr.DataTransfer = 1'b0;
      #1;
      chk("cr_owner0_route", 32'(req_cr_valid_o), 32'h1);
      chk("cd_beat0_route", 32'(req_cd_valid_o), 32'h2);
      chk("cd_beat0_data", req_cd_o.data, 32'hD0);
      tick();
      cr_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         cd = '{data: 32'(32'hD0 + i), last: (i == 3)};
         #1;
         chk("cd_beat_route", 32'(req_cd_valid_o), 32'h2);
         chk("cd_beat_ready", 32'(cd_ready_o), 32'h1);
         chk("cd_beat_data", req_cd_o.data, 32'(32'hD0 + i));
         tick();
      end
      #1;
      chk("cd_empty_ready", 32'(cd_ready_o), 32'h0);
      chk("cd_empty_route", 32'(req_cd_valid_o), 32'h0);
      cd_valid = 1'b0;

      // Fill CD owner queue, then a data-carrying CR must stall
      req_ac_valid = 2'b01; ac_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      req_ac_valid = 2'b00; cr_valid = 1'b1; cr.DataTransfer = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      cr_valid = 1'b0; req_ac_valid = 2'b10;
      tick();
      req_ac_valid = 2'b00; cr_valid = 1'b1;
      #1;
      chk("stall_cr_ready", 32'(cr_ready_o), 32'h0);
      tick();
      cd_valid = 1'b1; cd = '{data: 32'hE0, last: 1'b1};
      #1;
      chk("stall_cr_ready_cd_pop", 32'(cr_ready_o), 32'h0);
      chk("stall_cd_route", 32'(req_cd_valid_o), 32'h1);
      tick();
      cd_valid = 1'b0;
      #1;
      chk("unstall_cr_ready", 32'(cr_ready_o), 32'h1);
      chk("unstall_cr_route", 32'(req_cr_valid_o), 32'h2);
      tick();
      cr_valid = 1'b0; cd_valid = 1'b1;
      exp_route = '{2'b01, 2'b01, 2'b01, 2'b10};
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cd_drain_route", 32'(req_cd_valid_o), 32'(exp_route[i]));
         tick();
      end
      cd_valid = 1'b0;

      // Reset with three outstanding snoops
      req_ac_valid = 2'b10; ac_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      rst_ni = 1'b0;
      req_ac_valid = 2'b11; cr_valid = 1'b1; cd_valid = 1'b1; cr = '0;
      #1;
      chk_all_quiet("rst2");
      tick();
      rst_ni = 1'b1;
      #1;
      chk("rst2_cr_empty", 32'(cr_ready_o), 32'h0);
      chk("rst2_cd_empty", 32'(cd_ready_o), 32'h0);
      chk("rst2_first_grant", 32'(req_ac_ready_o), 32'h1);
      chk("rst2_first_addr", 32'(ac_o.addr), 32'h100);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
